// File: rtl/seq_series_sum_pkg.sv
// Shared types and constants for the series-sum engine: FSM state encoding,
// series mode constants and the default result-width helper.
package seq_series_sum_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic MODE_EVEN = 1'b0;
    localparam logic MODE_ODD  = 1'b1;

    // Wide enough for the odd-series worst case, which is the larger of the two.
    function automatic int sum_w(input int n_w);
        return 2 * n_w - 1;
    endfunction

endpackage

// File: rtl/seq_series_sum_if.sv
// Request/result bundle between a controller (master) and the series-sum
// engine (slave). Widths follow the engine's N_W / S_W parameters.
interface seq_series_sum_if
    import seq_series_sum_pkg::*;
#(
    parameter int N_W = 4,
    parameter int S_W = sum_w(N_W)
);
    logic           start;
    logic           mode;
    logic [N_W-1:0] N;
    logic [S_W-1:0] S;
    logic           busy;
    logic           done;
    logic           ovf;

    modport master (output start, mode, N, input S, busy, done, ovf);
    modport slave  (input start, mode, N, output S, busy, done, ovf);
endinterface

// File: rtl/seq_series_acc.sv
// S_W-bit accumulator with clear, add-enable and sticky carry-out detect.
// SEQ_SERIES_SUM_SAT_EN: clamp to all-ones once overflowed; otherwise wrap.
module seq_series_acc
    import seq_series_sum_pkg::*;
#(
    parameter int S_W = 7,
    parameter int T_W = 5
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clr_i,
    input  logic           add_i,
    input  logic [T_W-1:0] term_i,
    output logic [S_W-1:0] acc_o,
    output logic           ovf_o
);
    // One guard bit above the wider operand so the carry is never lost.
    localparam int W = ((S_W > T_W) ? S_W : T_W) + 1;

    logic [S_W-1:0] acc_q, acc_d;
    logic           ovf_q, ovf_d;
    logic [W-1:0]   sum;
    logic           carry;

    always_comb begin
        sum   = W'(acc_q) + W'(term_i);
        carry = |(sum >> S_W);
        acc_d = acc_q;
        ovf_d = ovf_q;
        if (clr_i) begin
            acc_d = '0;
            ovf_d = 1'b0;
        end else if (add_i) begin
            ovf_d = ovf_q | carry;
`ifdef SEQ_SERIES_SUM_SAT_EN
            acc_d = (ovf_q | carry) ? '1 : sum[S_W-1:0];
`else
            acc_d = sum[S_W-1:0];
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            ovf_q <= ovf_d;
        end
    end

    assign acc_o = acc_q;
    assign ovf_o = ovf_q;
endmodule

// File: rtl/seq_series_sum.sv
// Iterative series-sum engine: one term per clock, even (2+4+..) or odd
// (1+3+..) series up to N. Overflow policy set by SEQ_SERIES_SUM_SAT_EN.
module seq_series_sum
    import seq_series_sum_pkg::*;
#(
    parameter int N_W = 4,
    parameter int S_W = sum_w(N_W)
) (
    input  logic             clk,
    input  logic             rst,
    seq_series_sum_if.slave  bus
);
    localparam int T_W = N_W + 1;

    state_t         state_q, state_d;
    logic [N_W-1:0] n_q, n_d;
    logic [T_W-1:0] term_q, term_d;
    logic [S_W-1:0] s_q, s_d;
    logic           ovf_q, ovf_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;

    logic           acc_clr, acc_add, acc_ovf, term_le;
    logic [S_W-1:0] acc;

    // term_q carries an extra bit so N+2 never wraps below N.
    assign term_le = (term_q <= {1'b0, n_q});
    assign acc_clr = (state_q == ST_IDLE) && bus.start;
    assign acc_add = (state_q == ST_RUN) && term_le;

    seq_series_acc #(.S_W(S_W), .T_W(T_W)) u_acc (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (acc_clr),
        .add_i  (acc_add),
        .term_i (term_q),
        .acc_o  (acc),
        .ovf_o  (acc_ovf)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (bus.start) state_d = ST_RUN;
            ST_RUN:  if (!term_le)  state_d = ST_DONE;
            ST_DONE:                state_d = ST_IDLE;
            default:                state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        n_d    = n_q;
        term_d = term_q;
        s_d    = s_q;
        ovf_d  = ovf_q;
        busy_d = (state_d != ST_IDLE);
        done_d = 1'b0;
        if (acc_clr) begin
            n_d    = bus.N;
            term_d = (bus.mode == MODE_ODD) ? T_W'(1) : T_W'(2);
        end else if (acc_add) begin
            term_d = term_q + T_W'(2);
        end else if (state_q == ST_RUN) begin
            s_d    = acc;
            ovf_d  = acc_ovf;
            done_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n_q    <= '0;
            term_q <= '0;
            s_q    <= '0;
            ovf_q  <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            n_q    <= n_d;
            term_q <= term_d;
            s_q    <= s_d;
            ovf_q  <= ovf_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign bus.S    = s_q;
    assign bus.ovf  = ovf_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
endmodule

// File: tb/tb_seq_series_sum.sv
// Self-checking bench: directed, exhaustive and random operations against a
// closed-form model, plus start-ignore, mid-run reset and a narrow-S instance.
module tb_seq_series_sum;
    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    seq_series_sum_if #(.N_W(4), .S_W(7)) bus_a ();
    seq_series_sum_if #(.N_W(4), .S_W(5)) bus_b ();

    seq_series_sum #(.N_W(4), .S_W(7)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    seq_series_sum #(.N_W(4), .S_W(5)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    // Closed-form reference: k terms, even sum k(k+1), odd sum k^2.
    function automatic int exp_k(input logic m, input int n);
        return m ? (n + 1) / 2 : n / 2;
    endfunction

    function automatic int exp_sum(input logic m, input int n);
        int k;
        k = exp_k(m, n);
        return m ? k * k : k * (k + 1);
    endfunction

    // Drives one operation on dut_a; optionally pokes start during RUN and DONE.
    task automatic run_op(input logic m, input logic [3:0] n, input bit poke,
                          output logic [6:0] s, output logic o, output int lat,
                          output bit held_ok, output bit post_ok);
        logic [6:0] s0;
        lat = -1; held_ok = 1'b1; post_ok = 1'b1; s = 'x; o = 1'bx;
        @(negedge clk);
        bus_a.start = 1'b1; bus_a.mode = m; bus_a.N = n;
        s0 = bus_a.S;
        @(posedge clk); #1;
        bus_a.start = 1'b0;
        if (bus_a.busy !== 1'b1) held_ok = 1'b0;
        if (poke) begin
            bus_a.start = 1'b1; bus_a.mode = ~m; bus_a.N = ~n;
        end
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            bus_a.start = 1'b0;
            if (bus_a.done === 1'b1) begin
                lat = c; s = bus_a.S; o = bus_a.ovf;
                break;
            end
            if (bus_a.S !== s0 || bus_a.busy !== 1'b1) held_ok = 1'b0;
        end
        if (lat > 0) begin
            if (poke) begin
                bus_a.start = 1'b1; bus_a.mode = m; bus_a.N = ~n;
            end
            @(posedge clk); #1;
            bus_a.start = 1'b0;
            if (bus_a.done !== 1'b0 || bus_a.busy !== 1'b0 || bus_a.S !== s) post_ok = 1'b0;
        end
    endtask

    task automatic test_reset();
        n_cmp++;
        if ({bus_a.S, bus_a.busy, bus_a.done, bus_a.ovf} !== 10'd0) begin
            n_err++;
            $display("FAIL reset_a: got S=%0d busy=%b done=%b ovf=%b, want all 0",
                     bus_a.S, bus_a.busy, bus_a.done, bus_a.ovf);
        end
        n_cmp++;
        if ({bus_b.S, bus_b.busy, bus_b.done, bus_b.ovf} !== 8'd0) begin
            n_err++;
            $display("FAIL reset_b: got S=%0d busy=%b done=%b ovf=%b, want all 0",
                     bus_b.S, bus_b.busy, bus_b.done, bus_b.ovf);
        end
    endtask

    task automatic test_directed();
        bit dm[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        int dn[6] = '{10, 15, 15, 0, 0, 1};
        int ds[6] = '{30, 64, 56, 0, 0, 0};
        int dl[6] = '{6, 9, 8, 1, 1, 1};
        logic [6:0] s; logic o; int lat; bit h, p;
        for (int i = 0; i < 6; i++) begin
            run_op(dm[i], 4'(dn[i]), 1'b0, s, o, lat, h, p);
            n_cmp++;
            if (s !== 7'(ds[i]) || o !== 1'b0 || lat != dl[i] || !h || !p) begin
                n_err++;
                $display("FAIL directed m=%0d N=%0d: got S=%0d ovf=%b lat=%0d held=%0d post=%0d, want S=%0d ovf=0 lat=%0d held=1 post=1",
                         dm[i], dn[i], s, o, lat, h, p, ds[i], dl[i]);
            end
        end
    endtask

    task automatic test_sweep();
        logic [6:0] s; logic o; int lat; bit h, p;
        for (int m = 0; m < 2; m++) begin
            for (int n = 0; n < 16; n++) begin
                run_op(m[0], 4'(n), 1'b0, s, o, lat, h, p);
                n_cmp++;
                if (s !== 7'(exp_sum(m[0], n)) || o !== (exp_sum(m[0], n) > 127) ||
                    lat != exp_k(m[0], n) + 1 || !h || !p) begin
                    n_err++;
                    $display("FAIL sweep m=%0d N=%0d: got S=%0d ovf=%b lat=%0d held=%0d post=%0d, want S=%0d lat=%0d",
                             m, n, s, o, lat, h, p, exp_sum(m[0], n), exp_k(m[0], n) + 1);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [6:0] s; logic o; int lat; bit h, p;
        logic m; int n;
        for (int i = 0; i < 20; i++) begin
            m = 1'($urandom_range(0, 1));
            n = int'($urandom_range(0, 15));
            run_op(m, 4'(n), 1'b0, s, o, lat, h, p);
            n_cmp++;
            if (s !== 7'(exp_sum(m, n)) || lat != exp_k(m, n) + 1 || !h || !p) begin
                n_err++;
                $display("FAIL random m=%0d N=%0d: got S=%0d lat=%0d held=%0d post=%0d, want S=%0d lat=%0d",
                         m, n, s, lat, h, p, exp_sum(m, n), exp_k(m, n) + 1);
            end
        end
    endtask

    task automatic test_start_ignored();
        logic [6:0] s; logic o; int lat; bit h, p;
        bit pm[3] = '{1'b0, 1'b1, 1'b0};
        int pn[3] = '{10, 7, 1};
        for (int i = 0; i < 3; i++) begin
            run_op(pm[i], 4'(pn[i]), 1'b1, s, o, lat, h, p);
            n_cmp++;
            if (s !== 7'(exp_sum(pm[i], pn[i])) || lat != exp_k(pm[i], pn[i]) + 1 || !h || !p) begin
                n_err++;
                $display("FAIL start_ignored m=%0d N=%0d: got S=%0d lat=%0d held=%0d post=%0d, want S=%0d lat=%0d",
                         pm[i], pn[i], s, lat, h, p, exp_sum(pm[i], pn[i]), exp_k(pm[i], pn[i]) + 1);
            end
        end
    endtask

    task automatic test_reset_midrun();
        logic [6:0] s; logic o; int lat; bit h, p;
        run_op(1'b0, 4'd10, 1'b0, s, o, lat, h, p);
        n_cmp++;
        if (s !== 7'd30) begin
            n_err++;
            $display("FAIL pre_reset_op: got S=%0d, want 30", s);
        end
        @(negedge clk);
        bus_a.start = 1'b1; bus_a.mode = 1'b1; bus_a.N = 4'd15;
        @(posedge clk); #1;
        bus_a.start = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        n_cmp++;
        if ({bus_a.S, bus_a.busy, bus_a.done, bus_a.ovf} !== 10'd0) begin
            n_err++;
            $display("FAIL reset_midrun: got S=%0d busy=%b done=%b ovf=%b, want all 0",
                     bus_a.S, bus_a.busy, bus_a.done, bus_a.ovf);
        end
        @(negedge clk);
        rst = 1'b0;
        run_op(1'b0, 4'd6, 1'b0, s, o, lat, h, p);
        n_cmp++;
        if (s !== 7'd12 || o !== 1'b0 || lat != 4 || !h || !p) begin
            n_err++;
            $display("FAIL after_reset_op: got S=%0d ovf=%b lat=%0d held=%0d post=%0d, want S=12 ovf=0 lat=4",
                     s, o, lat, h, p);
        end
    endtask

    task automatic test_narrow();
        bit tm[2] = '{1'b1, 1'b0};
        int tn[2] = '{15, 4};
        int sum, ws; logic wo; int lat;
        for (int i = 0; i < 2; i++) begin
            sum = exp_sum(tm[i], tn[i]);
            wo  = (sum > 31);
`ifdef SEQ_SERIES_SUM_SAT_EN
            ws  = wo ? 31 : sum;
`else
            ws  = sum % 32;
`endif
            @(negedge clk);
            bus_b.start = 1'b1; bus_b.mode = tm[i]; bus_b.N = 4'(tn[i]);
            @(posedge clk); #1;
            bus_b.start = 1'b0;
            lat = -1;
            for (int c = 1; c <= 40; c++) begin
                @(posedge clk); #1;
                if (bus_b.done === 1'b1) begin lat = c; break; end
            end
            n_cmp++;
            if (bus_b.S !== 5'(ws) || bus_b.ovf !== wo || lat != exp_k(tm[i], tn[i]) + 1) begin
                n_err++;
                $display("FAIL narrow m=%0d N=%0d: got S=%0d ovf=%b lat=%0d, want S=%0d ovf=%b lat=%0d",
                         tm[i], tn[i], bus_b.S, bus_b.ovf, lat, ws, wo, exp_k(tm[i], tn[i]) + 1);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rst = 1'b1;
        bus_a.start = 1'b0; bus_a.mode = 1'b0; bus_a.N = '0;
        bus_b.start = 1'b0; bus_b.mode = 1'b0; bus_b.N = '0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk);
        rst = 1'b0;
        test_directed();
        test_sweep();
        test_random();
        test_start_ignored();
        test_reset_midrun();
        test_narrow();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
